// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
//   Shared types and constants for the I2C responder (i2c_slave) and its bus
//   front end (i2c_bus_sync).
//   Contents:
//     state_t      responder FSM states
//     I2C_ACK      SDA level of an acknowledge
//     I2C_NACK     SDA level of a not-acknowledge
//     I2C_RW_READ  R/W bit value selecting a read transfer
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
//   Brings SCL/SDA into the clk domain and decodes bus events.
//   Parameters:
//     SYNC_STAGES  synchroniser depth (>= 2)
//   Ports:
//     clk_i        system clock
//     rst_i        asynchronous active-high reset
//     scl_i        raw SCL
//     sda_i        raw SDA (wire level)
//     scl_rise_o   1-clk pulse, synced SCL 0->1
//     scl_fall_o   1-clk pulse, synced SCL 1->0
//     start_det_o  1-clk pulse, SDA 1->0 while SCL high
//     stop_det_o   1-clk pulse, SDA 0->1 while SCL high
//     sda_s_o      synchronised SDA level
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level (both lines high) so that leaving reset
  // never fabricates a START or STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise_o  = scl_s & ~scl_dly_q;
  assign scl_fall_o  = ~scl_s & scl_dly_q;
  // SCL must be high on both sides of the SDA transition.
  assign start_det_o = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign sda_s_o     = sda_s;

endmodule

// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave
//   I2C responder: detects START/STOP, matches a 7-bit address, ACKs,
//   receives write bytes and transmits read bytes on a wired-AND SDA.
//   Parameters:
//     SLV_ADDR     7-bit address answered
//     SYNC_STAGES  synchroniser depth for SCL/SDA (>= 2)
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset
//     SCL        bus clock from the master
//     iSDA       SDA as seen on the wire
//     oSDA       SDA drive: 1 = released, 0 = pull low
//     DataIn     byte to transmit, captured when DataReq pulses
//     DataOut    last byte received on a write
//     DataValid  1-clk pulse, DataOut updated
//     DataReq    1-clk pulse, DataIn captured into the TX shifter
//     Busy       high while addressed (ACK slot through read ACK)
// -----------------------------------------------------------------------------
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  input  logic       iSDA,
  output logic       oSDA,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       DataReq,
  output logic       Busy
);

  import i2c_pkg::*;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (SCL),
    .sda_i       (iSDA),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_s_o     (sda_s)
  );

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  rx_q, rx_d;      // previously received bits of the current byte
  logic [6:0]  tx_q, tx_d;      // remaining bits 6..0 of the byte being sent
  logic        rw_q, rw_d;
  logic        phase_q, phase_d; // ACK slot: drive pending / master ACK seen
  logic        sda_q, sda_d;
  logic [7:0]  dout_q, dout_d;
  logic        dv_q, dv_d;
  logic        req_q, req_d;
  logic [7:0]  rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      rw_q    <= 1'b0;
      phase_q <= 1'b0;
      sda_q   <= 1'b1;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rw_q    <= rw_d;
      phase_q <= phase_d;
      sda_q   <= sda_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rw_d    = rw_q;
    phase_d = phase_q;
    sda_d   = sda_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    req_d   = 1'b0;
    rx_next = {rx_q, sda_s};

    // Bus conditions pre-empt any bit activity in the same clk.
    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      sda_d   = 1'b1;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      phase_d = 1'b0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: sda_d = 1'b1;

        ADDR: if (scl_rise) begin
          rx_d  = rx_next[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rw_d    = sda_s;
            phase_d = 1'b0;
            state_d = (rx_next[7:1] == SLV_ADDR) ? ADDR_ACK : WAIT_STOP;
          end
        end

        // First fall opens the ACK slot, second fall closes it.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_d   = I2C_ACK;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            cnt_d   = '0;
            if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
              tx_d    = DataIn[6:0];
              req_d   = 1'b1;
              sda_d   = DataIn[7];
              state_d = RD_DATA;
            end else begin
              sda_d   = 1'b1;
              state_d = WR_DATA;
            end
          end
        end

        WR_DATA: if (scl_rise) begin
          rx_d  = rx_next[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            dout_d  = rx_next;
            dv_d    = 1'b1;
            state_d = WR_ACK;
          end
        end

        // Bit 7 is already on the wire on entry; each fall advances one bit
        // and the fall ending bit 0 releases SDA for the master's ACK.
        RD_DATA: if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            sda_d   = 1'b1;
            phase_d = 1'b0;
            state_d = RD_ACK;
          end else begin
            sda_d = tx_q[6];
            tx_d  = {tx_q[5:0], 1'b0};
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_d = WAIT_STOP;
            else                   phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            tx_d    = DataIn[6:0];
            req_d   = 1'b1;
            sda_d   = DataIn[7];
            state_d = RD_DATA;
          end
        end

        WAIT_STOP: sda_d = 1'b1;

        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  assign oSDA      = sda_q;
  assign DataOut   = dout_q;
  assign DataValid = dv_q;
  assign DataReq   = req_q;
  assign Busy      = (state_q == ADDR_ACK) || (state_q == WR_DATA) ||
                     (state_q == WR_ACK)   || (state_q == RD_DATA) ||
                     (state_q == RD_ACK);

endmodule

// File: tb/tb_i2c_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave
//   Bus-level master (SCL period 16 clk, wired-AND SDA) driving i2c_slave.
//   A transaction-level model predicts ACKs, received bytes and read data;
//   write bytes go into a scoreboard queue that a monitor drains on DataValid.
// -----------------------------------------------------------------------------
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       osda;
  logic       sda_bus;
  logic [7:0] din = 8'hFF;
  logic [7:0] dout;
  logic       dv, dreq, busy;

  assign sda_bus = m_sda & osda;

  always #5 clk = ~clk;

  i2c_slave #(
    .SLV_ADDR(7'h2A),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SCL       (scl),
    .iSDA      (sda_bus),
    .oSDA      (osda),
    .DataIn    (din),
    .DataOut   (dout),
    .DataValid (dv),
    .DataReq   (dreq),
    .Busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int req_cnt = 0;
  int low_cnt = 0;
  logic dv_prev = 1'b0;
  logic req_prev = 1'b0;
  logic [7:0] exp_wr[$];   // bytes the slave must deliver on DataOut
  logic [7:0] rd_src[$];   // bytes the slave will be offered on DataIn
  logic [7:0] payload[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard for DataValid, DataIn source for DataReq.
  always @(negedge clk) begin
    if (dv) begin
      dv_cnt++;
      check("dv_width", dv_prev, 0);
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dv_unexpected: DataValid with DataOut=0x%0h, none expected", dout);
      end else begin
        check("dataout", dout, exp_wr.pop_front());
      end
    end
    if (dreq) begin
      req_cnt++;
      check("req_width", req_prev, 0);
      if (rd_src.size() != 0) void'(rd_src.pop_front());
    end
    if (rd_src.size() != 0) din = rd_src[0];
    else                    din = 8'hFF;
    if (!osda) low_cnt++;
    dv_prev  = dv;
    req_prev = dreq;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- bus master ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_start();
    tick(4); m_sda = 1'b1;
    tick(4); scl = 1'b1;
    tick(8); m_sda = 1'b0;
    tick(8); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(4); m_sda = 1'b0;
    tick(4); scl = 1'b1;
    tick(8); m_sda = 1'b1;
    tick(8);
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    tick(4); m_sda = b;
    tick(4); scl = 1'b1;
    tick(4); r = sda_bus;
    tick(4); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    bit_cycle(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, r);
      d[i] = r;
    end
    bit_cycle(mack, r);
  endtask

  // ---------------- transaction-level reference ----------------
  function automatic logic hits(input logic [6:0] a);
    return a == 7'h2A;
  endfunction

  task automatic do_write(input logic [6:0] a, input logic send_stop);
    logic ack;
    int   dv0;
    dv0 = dv_cnt;
    low_cnt = 0;
    bus_start();
    wr_byte({a, 1'b0}, ack);
    check("addr_ack_w", ack, hits(a) ? 0 : 1);
    check("busy_addr_w", busy, hits(a));
    for (int i = 0; i < payload.size(); i++) begin
      if (hits(a)) exp_wr.push_back(payload[i]);
      wr_byte(payload[i], ack);
      check("data_ack", ack, hits(a) ? 0 : 1);
    end
    if (!hits(a)) check("miss_osda_low_w", low_cnt, 0);
    if (send_stop) begin
      bus_stop();
      check("busy_stop_w", busy, 0);
    end
    check("dv_count", dv_cnt - dv0, hits(a) ? payload.size() : 0);
  endtask

  task automatic do_read(input logic [6:0] a, input logic send_stop);
    logic ack;
    logic [7:0] d;
    int   req0;
    req0 = req_cnt;
    low_cnt = 0;
    if (hits(a)) for (int i = 0; i < payload.size(); i++) rd_src.push_back(payload[i]);
    bus_start();
    wr_byte({a, 1'b1}, ack);
    check("addr_ack_r", ack, hits(a) ? 0 : 1);
    if (hits(a)) begin
      for (int i = 0; i < payload.size(); i++) begin
        rd_byte((i == payload.size() - 1), d);
        check("rd_byte", d, payload[i]);
      end
      check("busy_after_nack", busy, 0);
    end else begin
      check("miss_osda_low_r", low_cnt, 0);
    end
    check("req_count", req_cnt - req0, hits(a) ? payload.size() : 0);
    if (send_stop) begin
      bus_stop();
      check("busy_stop_r", busy, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       ack, r;
    logic [7:0] keep;
    logic [6:0] a;
    int         n, dv0, req0;

    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    tick(3);
    check("rst_osda", osda, 1);
    check("rst_dout", dout, 0);
    check("rst_dv", dv, 0);
    check("rst_req", dreq, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // 1: plain write
    payload = '{8'h3C};
    do_write(7'h2A, 1'b1);
    check("t1_dout", dout, 8'h3C);

    // 2: address miss
    payload = '{8'($urandom), 8'($urandom)};
    do_write(7'h2B, 1'b1);

    // 3: read two bytes, ACK then NACK
    payload = '{8'hA5, 8'h0F};
    do_read(7'h2A, 1'b1);

    // 4: write, repeated START, read
    payload = '{8'h11};
    do_write(7'h2A, 1'b0);
    payload = '{8'($urandom)};
    do_read(7'h2A, 1'b1);
    check("t4_dout", dout, 8'h11);

    // 5: STOP in the middle of a data byte
    keep = dout;
    dv0  = dv_cnt;
    bus_start();
    wr_byte(8'h54, ack);
    check("t5_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), r);
    bus_stop();
    check("t5_osda", osda, 1);
    check("t5_busy", busy, 0);
    check("t5_dv", dv_cnt - dv0, 0);
    check("t5_dout", dout, keep);

    // 6: reset while the slave pulls SDA low during a read
    req0 = req_cnt;
    rd_src.push_back(8'h00);
    bus_start();
    wr_byte(8'h55, ack);
    check("t6_addr_ack", ack, 0);
    tick(6);
    check("t6_drive0", osda, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_osda", osda, 1);
    check("t6_rst_dout", dout, 0);
    tick(2);
    rst = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 9; i++) bit_cycle(1'b1, r);
    check("t6_quiet", low_cnt, 0);
    check("t6_busy", busy, 0);
    check("t6_req", req_cnt - req0, 1);
    payload = '{8'h77};
    do_write(7'h2A, 1'b1);
    check("t6_dout", dout, 8'h77);

    // 7: randomized transfers
    for (int k = 0; k < 8; k++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h2A;
      n = $urandom_range(1, 3);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) do_read(a, 1'b1);
      else                           do_write(a, 1'b1);
    end

    tick(4);
    check("sb_wr_empty", exp_wr.size(), 0);
    check("sb_rd_empty", rd_src.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
